// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST engine: FSM encoding, run modes,
// LFSR polynomial and error-counter width.
package adder_bist_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  localparam logic MODE_EXHAUSTIVE = 1'b0;
  localparam logic MODE_RANDOM     = 1'b1;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1 (bit k <-> x^(k+1))
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int unsigned ERR_CNT_W = 16;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bus between the adder BIST engine (master) and the adder under test (slave).
interface adder_bist_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (output dut_a, dut_b, dut_cin, input dut_sum, dut_cout);
  modport slave  (input dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_bist_lfsr.sv
// 32-bit Galois LFSR for random-mode vectors; load restores SEED, en advances one step.
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (load)    q <= SEED;
    else if (en) q <= lfsr_next(q);
  end

endmodule

// File: rtl/adder_bist.sv
// Adder BIST engine: drives exhaustive or LFSR vectors into an external adder and scores results.
// Define ADDER_BIST_FIRST_ERR_EN to capture the first failing vector and result of each run.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 0,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          num_vectors,
  adder_bist_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error_flag,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [2*WIDTH:0]     first_err_vec,
  output logic [WIDTH:0]       first_err_got
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned RW = WIDTH + 1;

  state_t        state;
  logic          mode_q;
  logic [31:0]   remaining;
  logic [3:0]    drain_cnt;
  logic [VW-1:0] vec_cnt;
  logic [31:0]   lfsr_q;
  logic          lfsr_unused;

  logic          launch;
  logic          drive;
  logic          sel_mode;
  logic [31:0]   total;
  logic [VW-1:0] vec_src;
  logic [RW-1:0] exp_next;
  logic [RW-1:0] got;
  logic          mismatch;

  logic [RW-1:0] exp_pipe [LATENCY+1];
  logic [LATENCY:0] vld_pipe;

  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  // The start edge itself drives vector 0, so RUN lasts exactly one cycle per vector.
  assign launch   = ((state == IDLE) || (state == DONE)) && start;
  assign drive    = launch || ((state == RUN) && (remaining != '0));
  assign sel_mode = launch ? mode : mode_q;

  always_comb begin
    total = '0;
    if (mode == MODE_RANDOM) total = (num_vectors == '0) ? 32'd1 : num_vectors;
    else                     total = 32'd1 << VW;

    vec_src = '0;
    if (sel_mode == MODE_RANDOM) vec_src = lfsr_q[VW-1:0];
    else if (!launch)            vec_src = vec_cnt;

    exp_next = RW'(vec_src[VW-1 -: WIDTH]) + RW'(vec_src[WIDTH:1]) + RW'(vec_src[0]);
  end

  adder_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .load (rst),
    .en   (drive && (sel_mode == MODE_RANDOM)),
    .q    (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[31:VW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_EXHAUSTIVE;
      remaining   <= '0;
      drain_cnt   <= '0;
      vec_cnt     <= '0;
      bus.dut_a   <= '0;
      bus.dut_b   <= '0;
      bus.dut_cin <= 1'b0;
    end else begin
      if (drive) begin
        {bus.dut_a, bus.dut_b, bus.dut_cin} <= vec_src;
        vec_cnt <= vec_src + VW'(1);
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            remaining <= total - 32'd1;
          end
        end
        RUN: begin
          if (remaining != '0) begin
            remaining <= remaining - 32'd1;
          end else if (LATENCY == 0) begin
            state <= DONE;
          end else begin
            state     <= DRAIN;
            drain_cnt <= 4'(LATENCY - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else                 drain_cnt <= drain_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expectation travels alongside its valid bit so it lines up with the adder's output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) exp_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= drive;
      exp_pipe[0] <= exp_next;
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  assign got      = {bus.dut_cout, bus.dut_sum};
  assign mismatch = vld_pipe[LATENCY] && ((exp_pipe[LATENCY] ^ got) != '0);

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      error_flag  <= 1'b0;
      error_count <= '0;
    end else if (mismatch) begin
      error_flag <= 1'b1;
      if (error_count != '1) error_count <= error_count + ERR_CNT_W'(1);
    end
  end

`ifdef ADDER_BIST_FIRST_ERR_EN
  logic [VW-1:0] vec_pipe [LATENCY+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LATENCY; i++) vec_pipe[i] <= '0;
    end else begin
      vec_pipe[0] <= vec_src;
      for (int unsigned i = 1; i <= LATENCY; i++) vec_pipe[i] <= vec_pipe[i-1];
    end
  end

  // error_flag still low means this is the run's first mismatch.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      first_err_vec <= '0;
      first_err_got <= '0;
    end else if (mismatch && !error_flag) begin
      first_err_vec <= vec_pipe[LATENCY];
      first_err_got <= got;
    end
  end
`else
  assign first_err_vec = '0;
  assign first_err_got = '0;
`endif

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand width of the adder under test; the legal range SHALL be 1..15.
REQ-002 Parameter LATENCY, default 0, sets the DUT pipeline depth in cycles from operand drive to result; the legal range SHALL be 0..8.
REQ-003 Parameter SEED, default 32'hACE1_0001, sets the LFSR reset value; it SHALL be nonzero.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: a run request, sampled only in IDLE or DONE.
REQ-007 Port mode, input, 1 bit, sampled with start: 0 selects exhaustive, 1 selects random.
REQ-008 Port num_vectors, input, 32 bits, sampled with start: the random-mode vector count; a value of 0 SHALL be treated as 1.
REQ-009 Ports dut_a and dut_b, output, WIDTH bits each: the operands driven to the DUT.
REQ-010 Port dut_cin, output, 1 bit: the carry-in driven to the DUT.
REQ-011 Ports dut_sum (input, WIDTH bits) and dut_cout (input, 1 bit): the DUT result.
REQ-012 Port busy, output, 1 bit: high while the state is RUN or DRAIN.
REQ-013 Port done, output, 1 bit: high while the state is DONE.
REQ-014 Port error_flag, output, 1 bit: a sticky flag that goes high on any mismatch during the current run.
REQ-015 Port error_count, output, 16 bits: the mismatch count for the current run, saturating at 16'hFFFF.
REQ-016 Ports first_err_vec (output, 2*WIDTH+1 bits) and first_err_got (output, WIDTH+1 bits): the first failing input vector and the first failing result.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-018 Transitions SHALL be:
- IDLE or DONE with start=1 goes to RUN.
- RUN goes to DRAIN after the last vector is driven.
- DRAIN goes to DONE after LATENCY cycles; LATENCY=0 skips DRAIN.
- start is ignored while busy.
REQ-019 Entering RUN SHALL clear error_flag, error_count, first_err_vec and first_err_got.
REQ-020 In RUN, exactly one vector {dut_a,dut_b,dut_cin} SHALL be driven per cycle.
REQ-021 Outside RUN, the dut_* outputs SHALL hold their last values.
REQ-022 Exhaustive mode SHALL drive the vector counter 0..2^(2*WIDTH+1)-1 in ascending order, concatenated as {a,b,cin}.
REQ-023 Random mode SHALL drive the low 2*WIDTH+1 bits of a 32-bit Galois LFSR (taps x^32+x^22+x^2+x+1), advanced once per RUN cycle, for num_vectors cycles.
REQ-024 The LFSR SHALL continue from its current state on each new run, not from SEED.
REQ-025 Expected values SHALL be computed as a+b+cin, zero-extended to WIDTH+1 bits, then delayed LATENCY cycles alongside a valid bit.
REQ-026 When the delayed valid bit is high, the block SHALL compare the expectation against {dut_cout,dut_sum}.
REQ-027 Any nonzero XOR in that comparison SHALL be a mismatch, and error_flag and error_count SHALL reflect it on the next edge.
REQ-028 Results arriving while the delayed valid bit is low SHALL be ignored.
REQ-029 The final vector's compare SHALL complete before DONE is entered.
REQ-030 error_count SHALL hold at 16'hFFFF once saturated.
REQ-031 error_flag SHALL be set even when error_count is saturated.

Reset
REQ-032 On rst=1, the block SHALL return to IDLE.
REQ-033 On rst=1, dut_a, dut_b, dut_cin, busy, done, error_flag, error_count, first_err_vec, first_err_got and the pipeline valid bits SHALL all be 0.
REQ-034 On rst=1, the LFSR SHALL load SEED.
REQ-035 Reset mid-run SHALL abort the run with no DONE state; results still in flight SHALL be discarded.

Configuration
REQ-036 With ADDER_BIST_FIRST_ERR_EN defined, the first mismatch of a run SHALL capture the delayed vector into first_err_vec and the DUT result into first_err_got.
REQ-037 With ADDER_BIST_FIRST_ERR_EN defined, later mismatches SHALL not overwrite the captured values.
REQ-038 Without ADDER_BIST_FIRST_ERR_EN, first_err_vec and first_err_got SHALL be tied to 0 and no capture registers SHALL exist.

Structure
REQ-039 Package adder_bist_pkg SHALL hold:
- the state enum;
- the MODE_EXHAUSTIVE and MODE_RANDOM constants;
- the LFSR tap constant;
- the error counter width (16).
REQ-040 A single sub-module, adder_bist_lfsr, SHALL implement the 32-bit LFSR with load and enable inputs.

Verification
REQ-041 Exhaustive run, ideal adder: WIDTH=4, LATENCY=0, mode=0, start pulse -> 512 cycles busy, then done=1, error_flag=0, error_count=0.
REQ-042 Stuck-at fault: WIDTH=4, LATENCY=2, dut_sum[0] stuck at 0 -> error_count=256; with the macro, first_err_vec=9'h001 and first_err_got=5'h00.
REQ-043 Random run with faulty carry: mode=1, num_vectors=1000, DUT cout forced to 0 -> error_flag=1 and error_count equals the number of driven vectors whose a+b+cin>15, checked against a bench model.
REQ-044 Saturation: WIDTH=8, exhaustive, DUT output inverted -> error_count=16'hFFFF at done and error_flag=1.
REQ-045 Reset mid-run: rst after 100 RUN cycles -> next cycle IDLE, busy=0, done=0, all counters 0; a subsequent start gives a clean exhaustive pass.
REQ-046 Start while busy: a start pulse in RUN -> no effect; the run length stays exactly 2^(2*WIDTH+1) plus LATENCY cycles.
